// File: rtl/mem_ctrl_if.sv
// Client and RAM bus bundle for mem_ctrl.
// Handshake: a client raises query_en with stable query fields and holds them
// until it sees its reply_en. reply_en is a single-cycle pulse that completes
// exactly one request, and the client may drop query_en in that cycle. RAM
// side: mem_a/mem_wr/mem_dout are registered by the controller, and mem_din
// carries the byte for the address presented one edge earlier.
interface mem_ctrl_if;
  logic        lsb_query_en;
  logic        lsb_query_type;
  logic [31:0] lsb_query_addr;
  logic [1:0]  lsb_data_width;
  logic [31:0] lsb_query_data;
  logic        lsb_reply_en;
  logic [31:0] lsb_reply_data;
  logic        if_query_en;
  logic [31:0] if_query_addr;
  logic        if_reply_en;
  logic [31:0] if_reply_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  // Client and RAM side
  modport master (
    output lsb_query_en, lsb_query_type, lsb_query_addr, lsb_data_width, lsb_query_data,
    input  lsb_reply_en, lsb_reply_data,
    output if_query_en, if_query_addr,
    input  if_reply_en, if_reply_data,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );

  // Controller side
  modport slave (
    input  lsb_query_en, lsb_query_type, lsb_query_addr, lsb_data_width, lsb_query_data,
    output lsb_reply_en, lsb_reply_data,
    input  if_query_en, if_query_addr,
    output if_reply_en, if_reply_data,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns LSB and fetch word requests into
// 1/2/4 byte RAM accesses and returns one reply pulse per request.
module mem_ctrl (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       flush_signal,
  input  logic       io_buffer_full,
  mem_ctrl_if.slave  bus,
  output logic [1:0] state_dbg
);
  localparam logic [31:0] IO_BASE = 32'h00030000;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        client_q, client_d;   // 1 = fetch, 0 = LSB
  logic [31:0] base_q, base_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  step_q, step_d;       // edges since accept
  logic [31:0] data_q, data_d;
  logic        flushed_q, flushed_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic        lsb_en_q, lsb_en_d;
  logic [31:0] lsb_data_q, lsb_data_d;
  logic        if_en_q, if_en_d;
  logic [31:0] if_data_q, if_data_d;

  logic        lsb_io, lsb_ok, take_lsb, take_if;
  logic [2:0]  lsb_n;
  logic [1:0]  cap_idx;

  // An IO write waits while the UART buffer is full; fetch may overtake it.
  // In DONE only the other client may be accepted, so the client being
  // replied to (still holding query_en) is never served twice.
  always_comb begin
    lsb_io   = bus.lsb_query_type && (bus.lsb_query_addr[17:16] == IO_BASE[17:16]);
    lsb_ok   = bus.lsb_query_en && !(lsb_io && io_buffer_full);
    take_lsb = lsb_ok && ((state_q == IDLE) || ((state_q == DONE) && client_q));
    take_if  = bus.if_query_en && ((state_q == IDLE) || ((state_q == DONE) && !client_q));
    case (bus.lsb_data_width)
      2'd0:    lsb_n = 3'd1;
      2'd1:    lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase
    // byte captured at step s belongs to address issued at step s-2
    cap_idx = step_q[1:0] - 2'd2;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    client_d   = client_q;
    base_d     = base_q;
    n_d        = n_q;
    step_d     = step_q;
    data_d     = data_q;
    flushed_d  = flushed_q;
    mem_a_d    = mem_a_q;
    dout_d     = dout_q;
    wr_d       = 1'b0;
    lsb_en_d   = 1'b0;
    lsb_data_d = lsb_data_q;
    if_en_d    = 1'b0;
    if_data_d  = if_data_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (!flush_signal && (take_lsb || take_if)) begin
          flushed_d = 1'b0;
          step_d    = 3'd1;
          client_d  = !take_lsb;
          if (take_lsb) begin
            base_d  = bus.lsb_query_addr;
            n_d     = lsb_n;
            mem_a_d = bus.lsb_query_addr;
            if (bus.lsb_query_type) begin
              data_d  = bus.lsb_query_data;
              state_d = WRITE;
              wr_d    = 1'b1;
              dout_d  = bus.lsb_query_data[7:0];
            end else begin
              data_d  = 32'h0;
              state_d = READ;
            end
          end else begin
            base_d  = bus.if_query_addr;
            n_d     = 3'd4;
            data_d  = 32'h0;
            mem_a_d = bus.if_query_addr;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (flush_signal) begin
          state_d = IDLE;
        end else begin
          if (step_q < n_q) mem_a_d = base_q + {29'd0, step_q};
          if (step_q >= 3'd2) data_d[{cap_idx, 3'b000} +: 8] = bus.mem_din;
          step_d = step_q + 3'd1;
          if (step_q == n_q + 3'd1) begin
            state_d = DONE;
            if (client_q) begin
              if_en_d   = 1'b1;
              if_data_d = data_d;
            end else begin
              lsb_en_d   = 1'b1;
              lsb_data_d = data_d;
            end
          end
        end
      end
      WRITE: begin
        // a write always finishes; flush only cancels its reply
        if (flush_signal) flushed_d = 1'b1;
        if (step_q < n_q) begin
          wr_d    = 1'b1;
          mem_a_d = base_q + {29'd0, step_q};
          dout_d  = data_q[{step_q[1:0], 3'b000} +: 8];
          step_d  = step_q + 3'd1;
        end else begin
          state_d = DONE;
          if (!(flushed_q || flush_signal)) begin
            lsb_en_d   = 1'b1;
            lsb_data_d = 32'h0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      client_q   <= 1'b0;
      base_q     <= 32'h0;
      n_q        <= 3'd0;
      step_q     <= 3'd0;
      data_q     <= 32'h0;
      flushed_q  <= 1'b0;
      mem_a_q    <= 32'h0;
      dout_q     <= 8'h0;
      wr_q       <= 1'b0;
      lsb_en_q   <= 1'b0;
      lsb_data_q <= 32'h0;
      if_en_q    <= 1'b0;
      if_data_q  <= 32'h0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      client_q   <= client_d;
      base_q     <= base_d;
      n_q        <= n_d;
      step_q     <= step_d;
      data_q     <= data_d;
      flushed_q  <= flushed_d;
      mem_a_q    <= mem_a_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      lsb_en_q   <= lsb_en_d;
      lsb_data_q <= lsb_data_d;
      if_en_q    <= if_en_d;
      if_data_q  <= if_data_d;
    end
  end

  // A flush arriving in the DONE cycle suppresses the pulse already raised
  assign bus.lsb_reply_en   = lsb_en_q && !flush_signal;
  assign bus.lsb_reply_data = lsb_data_q;
  assign bus.if_reply_en    = if_en_q && !flush_signal;
  assign bus.if_reply_data  = if_data_q;
  assign bus.mem_a          = mem_a_q;
  assign bus.mem_dout       = dout_q;
  assign bus.mem_wr         = wr_q;
  assign state_dbg          = state_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a synchronous byte RAM model.
module tb_mem_ctrl;
  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       rdy_in = 1'b1;
  logic       flush_signal = 1'b0;
  logic       io_buffer_full = 1'b0;
  logic [1:0] state_dbg;

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush_signal   (flush_signal),
    .io_buffer_full (io_buffer_full),
    .bus            (bus),
    .state_dbg      (state_dbg)
  );

  // clock
  always #5 clk_in = ~clk_in;

  // synchronous RAM, stalls together with the core
  logic [7:0] ram [0:1023];
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (bus.mem_wr) ram[bus.mem_a[9:0]] <= bus.mem_dout;
      bus.mem_din <= ram[bus.mem_a[9:0]];
    end
  end

  int total = 0;
  int bad   = 0;

  logic [31:0] log_a    [0:7];
  logic        log_wr   [0:7];
  logic [7:0]  log_dout [0:7];
  logic        post_en;
  logic        post_wr;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // driver: one LSB request, logs bus activity for the first cycles after accept
  task automatic lsb_txn(input logic t, input logic [31:0] a, input logic [1:0] w,
                         input logic [31:0] d, output int lat, output logic [31:0] rd);
    bus.lsb_query_type = t;
    bus.lsb_query_addr = a;
    bus.lsb_data_width = w;
    bus.lsb_query_data = d;
    bus.lsb_query_en   = 1'b1;
    lat = -1;
    rd  = 32'hxxxxxxxx;
    tick();
    for (int c = 0; c < 40; c++) begin
      if (c < 8) begin
        log_a[c]    = bus.mem_a;
        log_wr[c]   = bus.mem_wr;
        log_dout[c] = bus.mem_dout;
      end
      if (bus.lsb_reply_en) begin
        lat = c;
        rd  = bus.lsb_reply_data;
        break;
      end
      tick();
    end
    bus.lsb_query_en = 1'b0;
    tick();
    post_en = bus.lsb_reply_en;
    post_wr = bus.mem_wr;
  endtask

  task automatic test_reset();
    tick();
    total++;
    if ({bus.mem_a, bus.mem_dout, bus.mem_wr, bus.lsb_reply_en, bus.lsb_reply_data,
         bus.if_reply_en, bus.if_reply_data, state_dbg} !== 109'd0) begin
      bad++;
      $display("FAIL reset_outputs: got a=%h dout=%h wr=%b st=%0d want all zero",
               bus.mem_a, bus.mem_dout, bus.mem_wr, state_dbg);
    end
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_lsb_read();
    int lat;
    logic [31:0] rd;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    lsb_txn(1'b0, 32'h100, 2'd2, 32'h0, lat, rd);
    total++; if (lat !== 5) begin bad++; $display("FAIL lw_latency: got %0d want 5", lat); end
    total++; if (rd !== 32'h44332211) begin bad++; $display("FAIL lw_data: got %h want 44332211", rd); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (log_a[k] !== 32'h100 + k) begin
        bad++; $display("FAIL lw_addr%0d: got %h want %h", k, log_a[k], 32'h100 + k);
      end
    end
    total++; if (post_en !== 1'b0) begin bad++; $display("FAIL lw_single_pulse: got %b want 0", post_en); end
  endtask

  task automatic test_lsb_narrow();
    int lat;
    logic [31:0] rd;
    lsb_txn(1'b0, 32'h101, 2'd0, 32'h0, lat, rd);
    total++; if (lat !== 2) begin bad++; $display("FAIL lb_latency: got %0d want 2", lat); end
    total++; if (rd !== 32'h22) begin bad++; $display("FAIL lb_data: got %h want 00000022", rd); end
    lsb_txn(1'b0, 32'h102, 2'd1, 32'h0, lat, rd);
    total++; if (lat !== 3) begin bad++; $display("FAIL lh_latency: got %0d want 3", lat); end
    total++; if (rd !== 32'h4433) begin bad++; $display("FAIL lh_data: got %h want 00004433", rd); end
    lsb_txn(1'b0, 32'h100, 2'd3, 32'h0, lat, rd);
    total++; if (lat !== 5) begin bad++; $display("FAIL w3_latency: got %0d want 5", lat); end
    total++; if (rd !== 32'h44332211) begin bad++; $display("FAIL w3_data: got %h want 44332211", rd); end
  endtask

  task automatic test_lsb_write_half();
    int lat;
    logic [31:0] rd;
    lsb_txn(1'b1, 32'h202, 2'd1, 32'h0000BEEF, lat, rd);
    total++; if (lat !== 2) begin bad++; $display("FAIL sh_latency: got %0d want 2", lat); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL sh_reply_data: got %h want 0", rd); end
    total++;
    if ({log_wr[0], log_a[0], log_dout[0]} !== {1'b1, 32'h202, 8'hEF}) begin
      bad++; $display("FAIL sh_byte0: got wr=%b a=%h d=%h want 1 202 ef", log_wr[0], log_a[0], log_dout[0]);
    end
    total++;
    if ({log_wr[1], log_a[1], log_dout[1]} !== {1'b1, 32'h203, 8'hBE}) begin
      bad++; $display("FAIL sh_byte1: got wr=%b a=%h d=%h want 1 203 be", log_wr[1], log_a[1], log_dout[1]);
    end
    total++; if (log_wr[2] !== 1'b0) begin bad++; $display("FAIL sh_wr_low: got %b want 0", log_wr[2]); end
    total++; if (post_wr !== 1'b0) begin bad++; $display("FAIL sh_wr_after: got %b want 0", post_wr); end
    total++;
    if ({ram[10'h203], ram[10'h202]} !== 16'hBEEF) begin
      bad++; $display("FAIL sh_ram: got %h%h want beef", ram[10'h203], ram[10'h202]);
    end
  endtask

  task automatic test_priority();
    int lsb_c = -1;
    int if_c = -1;
    int lsb_n = 0;
    int if_n = 0;
    logic [31:0] a3 = 32'h0;
    logic [31:0] ifd = 32'h0;
    logic [31:0] lsd = 32'h0;
    ram[10'h108] = 8'h05; ram[10'h109] = 8'h06; ram[10'h10A] = 8'h07; ram[10'h10B] = 8'h08;
    bus.lsb_query_type = 1'b0; bus.lsb_query_addr = 32'h101; bus.lsb_data_width = 2'd0;
    bus.if_query_addr = 32'h108;
    bus.lsb_query_en = 1'b1;
    bus.if_query_en  = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      if (c == 3) a3 = bus.mem_a;
      if (bus.lsb_reply_en) begin
        lsb_n++; if (lsb_c < 0) lsb_c = c; lsd = bus.lsb_reply_data; bus.lsb_query_en = 1'b0;
      end
      if (bus.if_reply_en) begin
        if_n++; if (if_c < 0) if_c = c; ifd = bus.if_reply_data; bus.if_query_en = 1'b0;
      end
      tick();
    end
    total++; if (lsb_c !== 2) begin bad++; $display("FAIL prio_lsb_first: got %0d want 2", lsb_c); end
    total++; if (lsd !== 32'h22) begin bad++; $display("FAIL prio_lsb_data: got %h want 00000022", lsd); end
    total++; if (a3 !== 32'h108) begin bad++; $display("FAIL prio_fetch_accept: got %h want 00000108", a3); end
    total++; if (if_c !== 8) begin bad++; $display("FAIL prio_fetch_latency: got %0d want 8", if_c); end
    total++; if (ifd !== 32'h08070605) begin bad++; $display("FAIL prio_fetch_data: got %h want 08070605", ifd); end
    total++;
    if ({lsb_n, if_n} !== {32'd1, 32'd1}) begin
      bad++; $display("FAIL prio_pulses: got lsb=%0d if=%0d want 1 1", lsb_n, if_n);
    end
  endtask

  task automatic test_io_block();
    int wr_n = 0;
    int if_n = 0;
    int lsb_n = 0;
    int wr_n2 = 0;
    int lsb_n2 = 0;
    logic [31:0] ifd = 32'h0;
    logic [31:0] wa = 32'h0;
    logic [7:0] wd = 8'h0;
    ram[10'h10C] = 8'hA0; ram[10'h10D] = 8'hA1; ram[10'h10E] = 8'hA2; ram[10'h10F] = 8'hA3;
    io_buffer_full = 1'b1;
    bus.lsb_query_type = 1'b1; bus.lsb_query_addr = 32'h00030000; bus.lsb_data_width = 2'd0;
    bus.lsb_query_data = 32'h0000005A;
    bus.if_query_addr = 32'h10C;
    bus.lsb_query_en = 1'b1;
    bus.if_query_en  = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      if (bus.mem_wr) wr_n++;
      if (bus.lsb_reply_en) lsb_n++;
      if (bus.if_reply_en) begin if_n++; ifd = bus.if_reply_data; bus.if_query_en = 1'b0; end
      tick();
    end
    total++; if (wr_n !== 0) begin bad++; $display("FAIL io_blocked_wr: got %0d want 0", wr_n); end
    total++; if (lsb_n !== 0) begin bad++; $display("FAIL io_blocked_reply: got %0d want 0", lsb_n); end
    total++; if (if_n !== 1) begin bad++; $display("FAIL io_fetch_pulses: got %0d want 1", if_n); end
    total++; if (ifd !== 32'hA3A2A1A0) begin bad++; $display("FAIL io_fetch_data: got %h want a3a2a1a0", ifd); end
    io_buffer_full = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.mem_wr) begin wr_n2++; wa = bus.mem_a; wd = bus.mem_dout; end
      if (bus.lsb_reply_en) begin lsb_n2++; bus.lsb_query_en = 1'b0; end
      tick();
    end
    bus.lsb_query_en = 1'b0;
    total++; if (wr_n2 !== 1) begin bad++; $display("FAIL io_wr_count: got %0d want 1", wr_n2); end
    total++;
    if ({wa, wd} !== {32'h00030000, 8'h5A}) begin
      bad++; $display("FAIL io_wr_byte: got a=%h d=%h want 00030000 5a", wa, wd);
    end
    total++; if (lsb_n2 !== 1) begin bad++; $display("FAIL io_reply: got %0d want 1", lsb_n2); end
  endtask

  task automatic test_flush_fetch();
    int if_n = 0;
    int wr_n = 0;
    bus.if_query_addr = 32'h110;
    bus.if_query_en = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      if (bus.if_reply_en) if_n++;
      tick();
    end
    flush_signal = 1'b1;
    bus.if_query_en = 1'b0;
    tick();
    flush_signal = 1'b0;
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL flush_read_idle: got %0d want 0", state_dbg); end
    for (int c = 0; c < 8; c++) begin
      if (bus.if_reply_en) if_n++;
      if (bus.mem_wr) wr_n++;
      tick();
    end
    total++; if (if_n !== 0) begin bad++; $display("FAIL flush_read_reply: got %0d want 0", if_n); end
    total++; if (wr_n !== 0) begin bad++; $display("FAIL flush_read_wr: got %0d want 0", wr_n); end
  endtask

  task automatic test_flush_write();
    int wr_n = 0;
    int lsb_n = 0;
    bus.lsb_query_type = 1'b1; bus.lsb_query_addr = 32'h120; bus.lsb_data_width = 2'd2;
    bus.lsb_query_data = 32'hCAFEF00D;
    bus.lsb_query_en = 1'b1;
    tick();
    if (bus.mem_wr) wr_n++;
    flush_signal = 1'b1;
    bus.lsb_query_en = 1'b0;
    tick();
    flush_signal = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.mem_wr) wr_n++;
      if (bus.lsb_reply_en) lsb_n++;
      tick();
    end
    total++; if (wr_n !== 4) begin bad++; $display("FAIL flush_sw_bytes: got %0d want 4", wr_n); end
    total++; if (lsb_n !== 0) begin bad++; $display("FAIL flush_sw_reply: got %0d want 0", lsb_n); end
    total++;
    if ({ram[10'h123], ram[10'h122], ram[10'h121], ram[10'h120]} !== 32'hCAFEF00D) begin
      bad++; $display("FAIL flush_sw_ram: got %h%h%h%h want cafef00d",
                      ram[10'h123], ram[10'h122], ram[10'h121], ram[10'h120]);
    end
  endtask

  task automatic test_reset_mid_write();
    bus.lsb_query_type = 1'b1; bus.lsb_query_addr = 32'h130; bus.lsb_data_width = 2'd2;
    bus.lsb_query_data = 32'h11223344;
    bus.lsb_query_en = 1'b1;
    tick();
    tick();
    total++;
    if ({bus.mem_wr, bus.mem_dout} !== {1'b1, 8'h33}) begin
      bad++; $display("FAIL rst_pre_write: got wr=%b d=%h want 1 33", bus.mem_wr, bus.mem_dout);
    end
    #1 rst_in = 1'b0;
    #1;
    total++;
    if ({bus.mem_a, bus.mem_dout, bus.mem_wr, bus.lsb_reply_en, bus.lsb_reply_data,
         bus.if_reply_en, bus.if_reply_data, state_dbg} !== 109'd0) begin
      bad++; $display("FAIL rst_async: got a=%h dout=%h wr=%b st=%0d want all zero",
                      bus.mem_a, bus.mem_dout, bus.mem_wr, state_dbg);
    end
    bus.lsb_query_en = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    total++;
    if ({state_dbg, bus.mem_wr} !== 3'b000) begin
      bad++; $display("FAIL rst_after: got st=%0d wr=%b want 0 0", state_dbg, bus.mem_wr);
    end
  endtask

  task automatic test_rdy_stall();
    int lat = -1;
    int stall_rep = 0;
    logic [31:0] rd = 32'h0;
    ram[10'h140] = 8'hA1; ram[10'h141] = 8'hB2; ram[10'h142] = 8'hC3; ram[10'h143] = 8'hD4;
    bus.lsb_query_type = 1'b0; bus.lsb_query_addr = 32'h140; bus.lsb_data_width = 2'd2;
    bus.lsb_query_en = 1'b1;
    tick();
    tick();
    rdy_in = 1'b0;
    for (int c = 2; c < 5; c++) begin
      tick();
      if (bus.lsb_reply_en) stall_rep++;
    end
    total++; if (bus.mem_a !== 32'h141) begin bad++; $display("FAIL stall_addr_hold: got %h want 00000141", bus.mem_a); end
    rdy_in = 1'b1;
    for (int c = 4; c < 40; c++) begin
      if (bus.lsb_reply_en) begin lat = c; rd = bus.lsb_reply_data; break; end
      tick();
    end
    bus.lsb_query_en = 1'b0;
    tick();
    total++; if (stall_rep !== 0) begin bad++; $display("FAIL stall_reply_early: got %0d want 0", stall_rep); end
    total++; if (lat !== 8) begin bad++; $display("FAIL stall_latency: got %0d want 8", lat); end
    total++; if (rd !== 32'hD4C3B2A1) begin bad++; $display("FAIL stall_data: got %h want d4c3b2a1", rd); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    bus.lsb_query_en   = 1'b0;
    bus.lsb_query_type = 1'b0;
    bus.lsb_query_addr = 32'h0;
    bus.lsb_data_width = 2'd0;
    bus.lsb_query_data = 32'h0;
    bus.if_query_en    = 1'b0;
    bus.if_query_addr  = 32'h0;
    test_reset();
    test_lsb_read();
    test_lsb_narrow();
    test_lsb_write_half();
    test_priority();
    test_io_block();
    test_flush_fetch();
    test_flush_write();
    test_reset_mid_write();
    test_rdy_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
